// File: rtl/scope_pkg.sv
// scope_pkg -- shared definitions for the oscilloscope trigger block.
//   state_t           : capture state machine encoding
//   DEF_REC_LEN       : default record length (samples per capture)
//   DEF_AUTO_TIMEOUT  : default valid-sample count before a forced trigger
//   sat_inc16()       : 16-bit increment that sticks at 0xFFFF
package scope_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned DEF_REC_LEN      = 25000;
  localparam int unsigned DEF_AUTO_TIMEOUT = 50000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/trig_detect.sv
// trig_detect -- purely combinational edge comparison against a threshold.
//   prev    : previous ADC code
//   sample  : current ADC code
//   level   : trigger threshold
//   rising  : 1 = rising-edge crossing, 0 = falling-edge crossing
//   hit     : the pair (prev, sample) crosses level in the selected direction
// The caller is responsible for qualifying hit with sample validity and with
// whether prev actually holds a sample.
module trig_detect (
  input  logic [7:0] prev,
  input  logic [7:0] sample,
  input  logic [7:0] level,
  input  logic       rising,
  output logic       hit
);

  logic rise_hit;
  logic fall_hit;

  // An equal prev never counts as "before the crossing", so a flat trace
  // sitting on the threshold cannot retrigger.
  assign rise_hit = (prev < level) && (sample >= level);
  assign fall_hit = (prev > level) && (sample <= level);
  assign hit      = rising ? rise_hit : fall_hit;

endmodule

// File: rtl/scope_trigger.sv
// scope_trigger -- edge/auto trigger and record-length capture control for
// an 8-bit ADC stream, writing the triggering sample and the following
// samples into a downstream buffer.
//   adc_clk      : sole clock (ADC sample clock)
//   reset        : asynchronous, active-high reset
//   sample_valid : one-cycle strobe, sample holds a new code
//   sample       : ADC code (unsigned)
//   trig_level   : trigger threshold (unsigned)
//   trig_rising  : 1 = rising edge, 0 = falling edge
//   auto_mode    : enable forced trigger after AUTO_TIMEOUT armed samples
//   arm          : level request to start a capture
//   abort        : cancel any capture in progress (highest priority)
//   buf_empty    : downstream buffer fully drained
//   wr_en        : registered buffer write strobe
//   wr_data      : registered sample to write
//   busy         : ARMED, CAPTURE or DONE
//   capture_done : DONE
//   auto_trig    : last trigger was forced by timeout (sticky until re-arm)
module scope_trigger
  import scope_pkg::*;
#(
  parameter int unsigned REC_LEN      = DEF_REC_LEN,
  parameter int unsigned AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
  input  logic       adc_clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic [7:0] trig_level,
  input  logic       trig_rising,
  input  logic       auto_mode,
  input  logic       arm,
  input  logic       abort,
  input  logic       buf_empty,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       capture_done,
  output logic       auto_trig
);

  localparam logic [15:0] REC_LEN_W = 16'(REC_LEN);
  localparam logic [15:0] AUTO_W    = 16'(AUTO_TIMEOUT);

  state_t      state_reg, state_next;
  logic [7:0]  prev_reg, prev_next;
  logic        prev_valid_reg, prev_valid_next;
  logic [15:0] tmo_reg, tmo_next;
  logic [15:0] wcnt_reg, wcnt_next;
  logic        auto_trig_reg, auto_trig_next;
  logic        wr_en_reg, wr_en_next;
  logic [7:0]  wr_data_reg, wr_data_next;

  logic        edge_hit;
  logic        arm_entry;
  logic        armed_proc;
  logic        eff_prev_valid;
  logic [15:0] eff_tmo;
  logic [15:0] tmo_inc;
  logic        real_hit;
  logic        forced_hit;
  logic [15:0] wcnt_inc;

  trig_detect u_trig_detect (
    .prev   (prev_reg),
    .sample (sample),
    .level  (trig_level),
    .rising (trig_rising),
    .hit    (edge_hit)
  );

  // The cycle that moves us into ARMED already processes a coincident
  // sample as the first armed sample, so it sees a cleared history.
  assign arm_entry = arm && ((state_reg == ST_IDLE) ||
                             ((state_reg == ST_DONE) && buf_empty));
  assign armed_proc     = arm_entry || (state_reg == ST_ARMED);
  assign eff_prev_valid = arm_entry ? 1'b0  : prev_valid_reg;
  assign eff_tmo        = arm_entry ? 16'd0 : tmo_reg;
  assign tmo_inc        = sat_inc16(eff_tmo);
  assign wcnt_inc       = wcnt_reg + 16'd1;

  // A genuine edge wins over the timeout, so auto_trig only reports
  // captures that really were forced.
  assign real_hit   = sample_valid && eff_prev_valid && edge_hit;
  assign forced_hit = sample_valid && auto_mode && !real_hit && (tmo_inc >= AUTO_W);

  always_comb begin
    state_next      = state_reg;
    prev_next       = prev_reg;
    prev_valid_next = prev_valid_reg;
    tmo_next        = tmo_reg;
    wcnt_next       = wcnt_reg;
    auto_trig_next  = auto_trig_reg;
    wr_en_next      = 1'b0;
    wr_data_next    = wr_data_reg;

    if (abort) begin
      state_next = ST_IDLE;
    end else if (armed_proc) begin
      if (arm_entry) begin
        state_next      = ST_ARMED;
        prev_valid_next = 1'b0;
        tmo_next        = 16'd0;
        auto_trig_next  = 1'b0;
      end
      if (sample_valid) begin
        prev_next       = sample;
        prev_valid_next = 1'b1;
        tmo_next        = tmo_inc;
        if (real_hit || forced_hit) begin
          wr_en_next   = 1'b1;
          wr_data_next = sample;
          wcnt_next    = 16'd1;
          state_next   = (REC_LEN_W == 16'd1) ? ST_DONE : ST_CAPTURE;
          if (forced_hit) begin
            auto_trig_next = 1'b1;
          end
        end
      end
    end else if (state_reg == ST_CAPTURE) begin
      if (sample_valid) begin
        wr_en_next   = 1'b1;
        wr_data_next = sample;
        wcnt_next    = wcnt_inc;
        if (wcnt_inc >= REC_LEN_W) begin
          state_next = ST_DONE;
        end
      end
    end else if (state_reg == ST_DONE) begin
      if (buf_empty) begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      prev_reg       <= 8'h00;
      prev_valid_reg <= 1'b0;
      tmo_reg        <= 16'd0;
      wcnt_reg       <= 16'd0;
      auto_trig_reg  <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= 8'h00;
    end else begin
      state_reg      <= state_next;
      prev_reg       <= prev_next;
      prev_valid_reg <= prev_valid_next;
      tmo_reg        <= tmo_next;
      wcnt_reg       <= wcnt_next;
      auto_trig_reg  <= auto_trig_next;
      wr_en_reg      <= wr_en_next;
      wr_data_reg    <= wr_data_next;
    end
  end

  assign wr_en        = wr_en_reg;
  assign wr_data      = wr_data_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign capture_done = (state_reg == ST_DONE);
  assign auto_trig    = auto_trig_reg;

endmodule
